lif_membrane_update: RTL

//  Membrane-state register and update stage of the leaky integrate-and-fire neuron.

---
 rtl/lif_membrane_update_if.sv | 38 +++
 rtl/lif_membrane_update.sv | 110 +++++++++++
 2 files changed

// File: rtl/lif_membrane_update_if.sv
// ============================================================================
// Module      : lif_membrane_update_if
// Description : Bundles the time-step strobe, the input operands, the
//               decay_potential return path and the neuron outputs of the
//               LIF membrane update stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lif_membrane_update_if #(
  parameter int N_STAGE  = 10,
  parameter int REFRAC_W = 4
);
  localparam int W = N_STAGE + 2;

  logic                step;
  logic [W-1:0]        current;
  logic [W-1:0]        threshold;
  logic [REFRAC_W-1:0] refrac_cycles;
  logic [W-1:0]        beta_u;
  logic [W-1:0]        u;
  logic                spike;
  logic                refractory;

  // Upstream side: supplies the step operands and the decayed potential.
  modport master (
    output step, current, threshold, refrac_cycles, beta_u,
    input  u, spike, refractory
  );

  // Neuron side: consumes the operands and owns the membrane state.
  modport slave (
    input  step, current, threshold, refrac_cycles, beta_u,
    output u, spike, refractory
  );
endinterface

`default_nettype wire

// File: rtl/lif_membrane_update.sv
// ============================================================================
// Module      : lif_membrane_update
// Description : Membrane register and update stage of a leaky
//               integrate-and-fire neuron. Each step adds the input current
//               to the decayed potential with saturation, fires when the
//               threshold is reached and then sits out refrac_cycles steps.
//               Optional macro SUBTRACT_RESET_EN: on fire keep the residual
//               charge (u <= nxt - threshold) instead of resetting to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lif_membrane_update #(
  parameter int N_STAGE  = 10,
  parameter int REFRAC_W = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  lif_membrane_update_if.slave  bus
);

  localparam int W = N_STAGE + 2;

  localparam logic [0:0]          c_INTEGRATE  = 1'b0;
  localparam logic [0:0]          c_REFRACTORY = 1'b1;
  localparam logic [REFRAC_W-1:0] c_RC_ONE     = {{(REFRAC_W-1){1'b0}}, 1'b1};

  logic [0:0]          r_state, w_state_nxt;
  logic [W-1:0]        r_u, w_u_nxt;
  logic                r_spike, w_spike_nxt;
  logic [REFRAC_W-1:0] r_rc, w_rc_nxt;

  logic [W:0]   w_sum;
  logic [W-1:0] w_sat;
  logic [W-1:0] w_fire_u;
  logic         w_fire;

  // One extra bit on the sum so overflow clamps instead of wrapping.
  assign w_sum  = {1'b0, bus.beta_u} + {1'b0, bus.current};
  assign w_sat  = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
  assign w_fire = (w_sat >= bus.threshold);

`ifdef SUBTRACT_RESET_EN
  // Reset-by-subtraction; w_fire guarantees w_sat >= threshold.
  assign w_fire_u = w_sat - bus.threshold;
`else
  assign w_fire_u = {W{1'b0}};
`endif

  // State and datapath registers; async assert, sync release upstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_INTEGRATE;
      r_u     <= {W{1'b0}};
      r_spike <= 1'b0;
      r_rc    <= {REFRAC_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_u     <= w_u_nxt;
      r_spike <= w_spike_nxt;
      r_rc    <= w_rc_nxt;
    end
  end

  // Next-state: enter refractory on a fire with a nonzero period, leave on the last step.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.step) begin
      case (r_state)
        c_INTEGRATE: begin
          if (w_fire && (bus.refrac_cycles != {REFRAC_W{1'b0}}))
            w_state_nxt = c_REFRACTORY;
        end
        default: begin
          if (r_rc == c_RC_ONE)
            w_state_nxt = c_INTEGRATE;
        end
      endcase
    end
  end

  // Datapath: integrate/fire in INTEGRATE, decay-only countdown in REFRACTORY.
  always_comb begin
    w_u_nxt     = r_u;
    w_spike_nxt = 1'b0;
    w_rc_nxt    = r_rc;
    if (bus.step) begin
      if (r_state == c_INTEGRATE) begin
        if (w_fire) begin
          w_spike_nxt = 1'b1;
          w_u_nxt     = w_fire_u;
          if (bus.refrac_cycles != {REFRAC_W{1'b0}})
            w_rc_nxt = bus.refrac_cycles;
        end else begin
          w_u_nxt = w_sat;
        end
      end else begin
        w_u_nxt  = bus.beta_u;
        w_rc_nxt = r_rc - c_RC_ONE;
      end
    end
  end

  assign bus.u          = r_u;
  assign bus.spike      = r_spike;
  assign bus.refractory = (r_state == c_REFRACTORY);

endmodule

`default_nettype wire
